// File: rtl/sfx_pkg.sv
// Shared types, default widths and effect constants for the sound-effect player.
package sfx_pkg;

  typedef enum logic {
    IDLE,
    PLAYING
  } ch_state_t;

  localparam int TONE_W_DEF = 16;
  localparam int DUR_W_DEF  = 8;

  // Half-periods in 40 MHz cycles; death tone clipped to 16 bits
  localparam int PADDLE_HP = 40000;
  localparam int BLOCK_HP  = 20000;
  localparam int DEATH_HP  = 65535;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sfx_channel.sv
// One square-wave channel: IDLE/PLAYING FSM, phase and duration counters.
// Pitch sweep is present only when SFX_PITCH_SWEEP_EN is defined.
module sfx_channel
  import sfx_pkg::*;
#(
  parameter int TONE_W = TONE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              tick,
  input  logic [TONE_W-1:0] hp_in,
  input  logic [DUR_W-1:0]  dur_in,
`ifdef SFX_PITCH_SWEEP_EN
  input  logic [7:0]        sweep_in,
`endif
  output logic              active,
  output logic              level
);

  ch_state_t         state, state_n;
  logic [TONE_W-1:0] hp, hp_n;
  logic [TONE_W-1:0] ph, ph_n;
  logic [DUR_W-1:0]  rem, rem_n;
  logic              lvl_n;

`ifdef SFX_PITCH_SWEEP_EN
  localparam logic signed [TONE_W+1:0] HP_MAX = {2'b00, {TONE_W{1'b1}}};
  localparam logic signed [TONE_W+1:0] HP_MIN = (TONE_W+2)'(1);
  logic [7:0]               sw, sw_n;
  logic signed [TONE_W+1:0] swp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hp    <= '0;
      ph    <= '0;
      rem   <= '0;
      level <= 1'b0;
`ifdef SFX_PITCH_SWEEP_EN
      sw    <= '0;
`endif
    end else begin
      state <= state_n;
      hp    <= hp_n;
      ph    <= ph_n;
      rem   <= rem_n;
      level <= lvl_n;
`ifdef SFX_PITCH_SWEEP_EN
      sw    <= sw_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    hp_n    = hp;
    ph_n    = ph;
    rem_n   = rem;
    lvl_n   = level;
`ifdef SFX_PITCH_SWEEP_EN
    sw_n    = sw;
    swp     = $signed({2'b00, hp}) + $signed({{(TONE_W-6){sw[7]}}, sw});
`endif
    unique case (1'b1)
      trig && (dur_in != '0): begin
        state_n = PLAYING;
        hp_n    = hp_in;
        rem_n   = dur_in;
        ph_n    = '0;
        lvl_n   = (hp_in != '0);
`ifdef SFX_PITCH_SWEEP_EN
        sw_n    = sweep_in;
`endif
      end
      trig && (dur_in == '0): begin
        state_n = IDLE;
        lvl_n   = 1'b0;
      end
      !trig && (state == PLAYING): begin
        // >= keeps the wrap safe if a sweep shrinks hp below phase
        if (hp == '0) begin
          lvl_n = 1'b0;
        end else if (ph >= hp - 1'b1) begin
          ph_n  = '0;
          lvl_n = ~level;
        end else begin
          ph_n = ph + 1'b1;
        end
        if (tick) begin
`ifdef SFX_PITCH_SWEEP_EN
          if (hp != '0) begin
            if (swp < HP_MIN)      hp_n = TONE_W'(1);
            else if (swp > HP_MAX) hp_n = '1;
            else                   hp_n = swp[TONE_W-1:0];
          end
`endif
          if (rem == DUR_W'(1)) begin
            state_n = IDLE;
            lvl_n   = 1'b0;
          end else begin
            rem_n = rem - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign active = (state == PLAYING);

endmodule

// File: rtl/sfx_player.sv
// Multi-channel sound-effect player with ms prescaler and sigma-delta mixer.
// Optional per-channel pitch sweep: define SFX_PITCH_SWEEP_EN.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int CLK_HZ = 40000000,
  parameter int NUM_CH = 3,
  parameter int TONE_W = TONE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_CH-1:0]        TRIG,
  input  logic [NUM_CH*TONE_W-1:0] HALF_PERIOD,
  input  logic [NUM_CH*DUR_W-1:0]  DURATION_MS,
`ifdef SFX_PITCH_SWEEP_EN
  input  logic [NUM_CH*8-1:0]      SWEEP,
`endif
  input  logic                     MUTE,
  output logic [NUM_CH-1:0]        ACTIVE,
  output logic                     AUDIO
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(NUM_CH + 1);
  localparam logic [SW:0] NCH = (SW+1)'(NUM_CH);

  logic [PW-1:0]     pre;
  logic              tick;
  logic [NUM_CH-1:0] lv;
  logic [7:0]        lv8;
  logic [SW-1:0]     sum, acc;
  logic [SW:0]       tot;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pre <= '0;
    else       pre <= tick ? '0 : pre + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sfx_channel #(
      .TONE_W(TONE_W),
      .DUR_W (DUR_W)
    ) u_ch (
      .clk     (CLK),
      .rst     (RESET),
      .trig    (TRIG[i]),
      .tick    (tick),
      .hp_in   (HALF_PERIOD[i*TONE_W +: TONE_W]),
      .dur_in  (DURATION_MS[i*DUR_W +: DUR_W]),
`ifdef SFX_PITCH_SWEEP_EN
      .sweep_in(SWEEP[i*8 +: 8]),
`endif
      .active  (ACTIVE[i]),
      .level   (lv[i])
    );
  end

  always_comb begin
    lv8 = '0;
    lv8[NUM_CH-1:0] = lv;
    sum = SW'(popcount(lv8));
    tot = {1'b0, acc} + {1'b0, sum};
  end

  // Mute gates only the output bit so the duty stays exact on unmute
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc   <= '0;
      AUDIO <= 1'b0;
    end else if (tot >= NCH) begin
      acc   <= SW'(tot - NCH);
      AUDIO <= ~MUTE;
    end else begin
      acc   <= tot[SW-1:0];
      AUDIO <= 1'b0;
    end
  end

endmodule
